// File: rtl/rv32_hazard_unit.sv
// Hazard detection and operand forwarding for the rv32 in-order pipeline.
// Optional stall/forward statistics counters are enabled by defining RV32_HAZARD_STATS_EN.
module rv32_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_valid_in,
  input  logic                  flush_in,
  input  logic [4:0]            rs1_in,
  input  logic [4:0]            rs2_in,
  input  logic                  rs1_used_in,
  input  logic                  rs2_used_in,
  input  logic [4:0]            rd_in,
  input  logic                  rd_writeback_in,
  input  logic                  mem_read_en_in,
  input  logic [XLEN-1:0]       rs1_value_in,
  input  logic [XLEN-1:0]       rs2_value_in,
  input  logic [DEPTH*XLEN-1:0] stage_result_in,
  output logic                  stall_out,
  output logic [XLEN-1:0]       rs1_value_out,
  output logic [XLEN-1:0]       rs2_value_out,
  output logic                  rs1_fwd_out,
  output logic                  rs2_fwd_out,
`ifdef RV32_HAZARD_STATS_EN
  output logic [31:0]           stall_count_out,
  output logic [31:0]           fwd_count_out,
`endif
  output logic [DEPTH-1:0]      slot_valid_out
);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      wb_q, wb_d;
  logic [DEPTH-1:0]      load_q, load_d;
  logic [DEPTH-1:0][4:0] rd_q, rd_d;

  logic            accept_s;
  logic            rs1_hit_s, rs1_haz_s, rs2_hit_s, rs2_haz_s;
  logic [XLEN-1:0] rs1_fwd_val_s, rs2_fwd_val_s;

  // Scan oldest to youngest so the youngest matching slot overrides; returns {hit, load_hazard, value}.
  function automatic logic [XLEN+1:0] resolve(
    input logic [4:0]            rs,
    input logic                  used,
    input logic [DEPTH-1:0]      valid,
    input logic [DEPTH-1:0]      wb,
    input logic [DEPTH-1:0]      load,
    input logic [DEPTH-1:0][4:0] rd,
    input logic [DEPTH*XLEN-1:0] results
  );
    logic [XLEN+1:0] res;
    res = {1'b0, 1'b0, {XLEN{1'b0}}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && wb[i] && (rd[i] == rs) && (rs != 5'd0) && used) begin
        res = {1'b1, (load[i] && (i < LOAD_STAGE)), results[i*XLEN +: XLEN]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Operand lookup against the shadow pipeline.
  always_comb begin
    {rs1_hit_s, rs1_haz_s, rs1_fwd_val_s} =
      resolve(rs1_in, rs1_used_in, valid_q, wb_q, load_q, rd_q, stage_result_in);
    {rs2_hit_s, rs2_haz_s, rs2_fwd_val_s} =
      resolve(rs2_in, rs2_used_in, valid_q, wb_q, load_q, rd_q, stage_result_in);
  end

  // Operand selection and stall generation.
  always_comb begin
    stall_out     = 1'b0;
    rs1_value_out = rs1_value_in;
    rs2_value_out = rs2_value_in;
    rs1_fwd_out   = 1'b0;
    rs2_fwd_out   = 1'b0;
    if (issue_valid_in) begin
      stall_out = (rs1_hit_s && rs1_haz_s) || (rs2_hit_s && rs2_haz_s);
      if (rs1_hit_s && !rs1_haz_s) begin
        rs1_value_out = rs1_fwd_val_s;
        rs1_fwd_out   = 1'b1;
      end else begin
        rs1_value_out = rs1_value_in;
        rs1_fwd_out   = 1'b0;
      end
      if (rs2_hit_s && !rs2_haz_s) begin
        rs2_value_out = rs2_fwd_val_s;
        rs2_fwd_out   = 1'b1;
      end else begin
        rs2_value_out = rs2_value_in;
        rs2_fwd_out   = 1'b0;
      end
    end else begin
      stall_out = 1'b0;
    end
  end

  // Shadow pipeline advance; a stall or flush injects a bubble while older slots keep moving.
  always_comb begin
    accept_s = issue_valid_in && !stall_out && !flush_in;
    valid_d  = {valid_q[DEPTH-2:0], accept_s};
    wb_d     = {wb_q[DEPTH-2:0], rd_writeback_in};
    load_d   = {load_q[DEPTH-2:0], mem_read_en_in};
    rd_d     = {rd_q[DEPTH-2:0], rd_in};
  end

  // Shadow pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= {DEPTH{1'b0}};
      wb_q    <= {DEPTH{1'b0}};
      load_q  <= {DEPTH{1'b0}};
      rd_q    <= {(DEPTH*5){1'b0}};
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
    end
  end

  assign slot_valid_out = valid_q;

`ifdef RV32_HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] fwd_count_q, fwd_count_d;

  // Saturating statistics counters.
  always_comb begin
    if (stall_out && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
    if (accept_s && (rs1_fwd_out || rs2_fwd_out) && (fwd_count_q != 32'hFFFF_FFFF)) begin
      fwd_count_d = fwd_count_q + 32'd1;
    end else begin
      fwd_count_d = fwd_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= 32'd0;
      fwd_count_q   <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count_out = stall_count_q;
  assign fwd_count_out   = fwd_count_q;
`endif

endmodule

// File: tb/tb_rv32_hazard_unit.sv
// Directed-vector bench for rv32_hazard_unit (default parameters).
module tb_rv32_hazard_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  issue_valid_in, flush_in;
  logic [4:0]            rs1_in, rs2_in, rd_in;
  logic                  rs1_used_in, rs2_used_in, rd_writeback_in, mem_read_en_in;
  logic [XLEN-1:0]       rs1_value_in, rs2_value_in;
  logic [DEPTH*XLEN-1:0] stage_result_in;
  logic                  stall_out, rs1_fwd_out, rs2_fwd_out;
  logic [XLEN-1:0]       rs1_value_out, rs2_value_out;
  logic [DEPTH-1:0]      slot_valid_out;
`ifdef RV32_HAZARD_STATS_EN
  logic [31:0]           stall_count_out, fwd_count_out;
`endif

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  rv32_hazard_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .issue_valid_in  (issue_valid_in),
    .flush_in        (flush_in),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .rs1_used_in     (rs1_used_in),
    .rs2_used_in     (rs2_used_in),
    .rd_in           (rd_in),
    .rd_writeback_in (rd_writeback_in),
    .mem_read_en_in  (mem_read_en_in),
    .rs1_value_in    (rs1_value_in),
    .rs2_value_in    (rs2_value_in),
    .stage_result_in (stage_result_in),
    .stall_out       (stall_out),
    .rs1_value_out   (rs1_value_out),
    .rs2_value_out   (rs2_value_out),
    .rs1_fwd_out     (rs1_fwd_out),
    .rs2_fwd_out     (rs2_fwd_out),
`ifdef RV32_HAZARD_STATS_EN
    .stall_count_out (stall_count_out),
    .fwd_count_out   (fwd_count_out),
`endif
    .slot_valid_out  (slot_valid_out)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr_in();
    issue_valid_in  = 1'b0;
    flush_in        = 1'b0;
    rs1_in          = 5'd0;
    rs2_in          = 5'd0;
    rs1_used_in     = 1'b0;
    rs2_used_in     = 1'b0;
    rd_in           = 5'd0;
    rd_writeback_in = 1'b0;
    mem_read_en_in  = 1'b0;
    rs1_value_in    = 32'hAAAA_0001;
    rs2_value_in    = 32'h5555_0002;
  endtask

  task automatic set_res(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    stage_result_in = {s2, s1, s0};
  endtask

  // Drive a valid issue with the given destination and sources.
  task automatic issue(input logic [4:0] rd, input logic wb, input logic ld,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    issue_valid_in  = 1'b1;
    rd_in           = rd;
    rd_writeback_in = wb;
    mem_read_en_in  = ld;
    rs1_in          = r1;
    rs1_used_in     = u1;
    rs2_in          = r2;
    rs2_used_in     = u2;
  endtask

  initial begin
    reset_n = 1'b0;
    clr_in();
    set_res(32'h0, 32'h0, 32'h0);
    #12;
    check_vec("reset_slot_valid", 64'(slot_valid_out), 64'h0);
    check_vec("reset_stall", 64'(stall_out), 64'h0);

    // add rd=5
    @(negedge clk); reset_n = 1'b1; clr_in();
    issue(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check_vec("t1_stall", 64'(stall_out), 64'h0);

    // rs1=5 forwarded from slot 0
    @(negedge clk); clr_in(); set_res(32'h1234, 32'h0, 32'h0);
    issue(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check_vec("fwd_slot0_val", 64'(rs1_value_out), 64'h1234);
    check_vec("fwd_slot0_flag", 64'(rs1_fwd_out), 64'h1);
    check_vec("fwd_slot0_stall", 64'(stall_out), 64'h0);
    check_vec("fwd_slot0_rs2pass", 64'(rs2_value_out), 64'h5555_0002);
    check_vec("fwd_slot0_slots", 64'(slot_valid_out), 64'h1);

    // lw rd=7
    @(negedge clk); clr_in(); set_res(32'h0, 32'h0, 32'hCAFE_BABE);
    issue(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check_vec("lw_slots", 64'(slot_valid_out), 64'h3);

    // dependent rs2=7: two stall cycles
    @(negedge clk); clr_in();
    issue(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    check_vec("lu_stall1", 64'(stall_out), 64'h1);
    check_vec("lu_stall1_fwd", 64'(rs2_fwd_out), 64'h0);
    check_vec("lu_stall1_slots", 64'(slot_valid_out), 64'h7);
    @(negedge clk);
    #1;
    check_vec("lu_stall2", 64'(stall_out), 64'h1);
    check_vec("lu_stall2_slots", 64'(slot_valid_out), 64'h6);
    @(negedge clk);
    #1;
    check_vec("lu_fwd_stall", 64'(stall_out), 64'h0);
    check_vec("lu_fwd_val", 64'(rs2_value_out), 64'hCAFE_BABE);
    check_vec("lu_fwd_flag", 64'(rs2_fwd_out), 64'h1);
    check_vec("lu_fwd_slots", 64'(slot_valid_out), 64'h4);

    // two writers of x3, then a reader: youngest wins
    @(negedge clk); clr_in();
`ifdef RV32_HAZARD_STATS_EN
    #1;
    check_vec("stat_stall_cnt", 64'(stall_count_out), 64'd2);
    check_vec("stat_fwd_cnt", 64'(fwd_count_out), 64'd2);
`endif
    issue(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); clr_in();
    issue(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); clr_in(); set_res(32'h11, 32'h22, 32'h33);
    issue(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1);
    #1;
    check_vec("young_rs1", 64'(rs1_value_out), 64'h11);
    check_vec("young_rs2", 64'(rs2_value_out), 64'h11);
    check_vec("young_fwd", 64'({rs1_fwd_out, rs2_fwd_out}), 64'h3);

    // no valid issue: pass-through despite a matching slot
    @(negedge clk); clr_in(); rs1_value_in = 32'h77;
    rs1_in = 5'd3; rs1_used_in = 1'b1;
    #1;
    check_vec("idle_val", 64'(rs1_value_out), 64'h77);
    check_vec("idle_fwd", 64'(rs1_fwd_out), 64'h0);

    // load writing x0, then read x0: never matches
    @(negedge clk); clr_in(); set_res(32'hDEAD, 32'hBEEF, 32'h0);
    issue(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); clr_in(); rs1_value_in = 32'h0;
    issue(5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    check_vec("x0_val", 64'(rs1_value_out), 64'h0);
    check_vec("x0_fwd", 64'(rs1_fwd_out), 64'h0);
    check_vec("x0_stall", 64'(stall_out), 64'h0);

    // flushed rd=9 does not create a hazard
    @(negedge clk); clr_in();
    issue(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    flush_in = 1'b1;
    @(negedge clk); clr_in(); set_res(32'hBAD, 32'hBAD, 32'hBAD); rs1_value_in = 32'h9999;
    issue(5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    #1;
    check_vec("flush_val", 64'(rs1_value_out), 64'h9999);
    check_vec("flush_fwd", 64'(rs1_fwd_out), 64'h0);
    check_vec("flush_slots", 64'(slot_valid_out), 64'h6);

    // flush together with load-use stall
    @(negedge clk); clr_in(); set_res(32'h0, 32'h0, 32'h4444);
    issue(5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); clr_in();
    issue(5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
    flush_in = 1'b1;
    #1 check_vec("flush_stall", 64'(stall_out), 64'h1);
    @(negedge clk); flush_in = 1'b0;
    #1;
    check_vec("flush_stall_slots", 64'(slot_valid_out), 64'h6);
    check_vec("post_flush_stall", 64'(stall_out), 64'h1);
    @(negedge clk);
    issue(5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    #1;
    check_vec("slot2_load_val", 64'(rs1_value_out), 64'h4444);
    check_vec("slot2_load_stall", 64'(stall_out), 64'h0);

    // mid-run reset with rd=6 in flight
    @(negedge clk); clr_in();
    issue(5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); clr_in(); reset_n = 1'b0;
    #1;
    check_vec("mid_reset_slots", 64'(slot_valid_out), 64'h0);
`ifdef RV32_HAZARD_STATS_EN
    check_vec("mid_reset_stall_cnt", 64'(stall_count_out), 64'd0);
    check_vec("mid_reset_fwd_cnt", 64'(fwd_count_out), 64'd0);
`endif
    @(negedge clk); reset_n = 1'b1; set_res(32'h6666, 32'h6666, 32'h6666);
    issue(5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
    #1;
    check_vec("post_reset_val", 64'(rs1_value_out), 64'hAAAA_0001);
    check_vec("post_reset_stall", 64'(stall_out), 64'h0);

    @(negedge clk); clr_in();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/rv32_hazard_unit.md
Name: rv32_hazard_unit

Overview:
- Parametrised hazard and forwarding unit for the rv32 in-order pipeline; sits beside decode.
- Keeps a shadow pipeline of destination tags for the DEPTH stages after decode (default: execute, mem, writeback).
- Replaces register-file operands with in-flight results (forwarding). Asserts a stall when a load result is not yet available.
- Inserts bubbles on stall or flush.

Parameters:
- XLEN, 32, data width of operands and results
- DEPTH, 3, number of tracked stages after decode (slot 0 = execute, slot DEPTH-1 = writeback); legal range 2..8
- LOAD_STAGE, 2, lowest slot index at which a load's data is valid on stage_result_in; must be < DEPTH

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid_in  in  1  decode holds a valid instruction
- flush_in  in  1  discard the instruction being issued this cycle
- rs1_in  in  5  source register 1 index
- rs2_in  in  5  source register 2 index
- rs1_used_in  in  1  instruction reads rs1
- rs2_used_in  in  1  instruction reads rs2
- rd_in  in  5  destination register index
- rd_writeback_in  in  1  instruction writes rd
- mem_read_en_in  in  1  instruction is a load
- rs1_value_in  in  XLEN  register-file value for rs1
- rs2_value_in  in  XLEN  register-file value for rs2
- stage_result_in  in  DEPTH*XLEN  packed results; element i (bits i*XLEN +: XLEN) is slot i's result
- stall_out  out  1  decode and fetch must hold
- rs1_value_out  out  XLEN  resolved rs1 operand
- rs2_value_out  out  XLEN  resolved rs2 operand
- rs1_fwd_out  out  1  rs1_value_out taken from stage_result_in
- rs2_fwd_out  out  1  rs2_value_out taken from stage_result_in
- slot_valid_out  out  DEPTH  per-slot occupancy, for debug

Behaviour:
- Shadow slot fields: valid, rd[4:0], wb, load. Reset (async, reset_n low) clears all valid bits; slot_valid_out = 0.
- Each rising edge:
  - slot[i+1] <= slot[i] for i = 0..DEPTH-2.
  - slot[0] <= {issue_valid_in & ~stall_out & ~flush_in, rd_in, rd_writeback_in, mem_read_en_in}.
  - The entry in slot DEPTH-1 retires.
- Match rule for operand rsX:
  - A slot matches when valid & wb & rd == rsX & rsX != 0 & rsX_used_in.
  - Writes to x0 never match.
- Priority: the youngest matching slot (lowest index) wins. Older matches are ignored.
- Forward: when the winning slot i is not a load, or is a load with i >= LOAD_STAGE:
  - rsX_value_out = element i of stage_result_in
  - rsX_fwd_out = 1
- Load-use stall: when the winning slot i is a load with i < LOAD_STAGE, the stall term for rsX is 1; rsX_value_out is don't-care.
- No match: rsX_value_out = rsX_value_in, rsX_fwd_out = 0.
- stall_out = issue_valid_in & (stall term rs1 | stall term rs2).
  - Combinational, zero-cycle latency.
  - During a stall a bubble enters slot 0 and the older slots keep advancing, so the stall resolves by itself.
  - With LOAD_STAGE=2, an immediately dependent instruction stalls exactly 2 cycles.
- flush_in:
  - Inserts a bubble into slot 0 regardless of stall.
  - Does not invalidate older slots, which are already committed.
  - Simultaneous flush and stall: the bubble is inserted; stall_out still reflects the hazard.
- issue_valid_in = 0: stall_out = 0 and the outputs pass the register-file values through.
- Same rd in several slots: only the youngest is used.
- Reset asserted mid-operation: all slots are invalidated immediately. The first issue after reset_n rises sees no hazards.

Optional Feature:
- Macro: RV32_HAZARD_STATS_EN.
- When defined, two extra output ports are added:
  - stall_count_out (32), counts cycles with stall_out = 1
  - fwd_count_out (32), counts issued (non-stalled, non-flushed, valid) instructions with rs1_fwd_out | rs2_fwd_out
- Both counters saturate at 0xFFFFFFFF and are cleared by reset_n.
- When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then issue add rd=5; next cycle issue rs1=5 with stage_result_in slot0=0x1234 -> rs1_value_out=0x1234, rs1_fwd_out=1, stall_out=0.
- Issue lw rd=7, then dependent rs2=7 -> stall_out=1 for 2 cycles. Third cycle: forward from slot 2 with value 0xCAFEBABE, stall_out=0, slot_valid_out shows the bubbles.
- Slot0 rd=3 value 0x11 and slot1 rd=3 value 0x22, issue rs1=3 -> rs1_value_out=0x11 (youngest wins).
- Issue with rd=0 wb=1, then rs1=0 with rs1_value_in=0 -> no forward, rs1_value_out=0, stall_out=0.
- flush_in=1 with issue_valid_in=1 rd=9, then rs1=9 next cycle -> no match, rs1_value_out=rs1_value_in.
- With RV32_HAZARD_STATS_EN: run the load-use scenario -> stall_count_out=2, fwd_count_out=1. Assert reset_n low mid-run -> both counters 0 and slot_valid_out=0 immediately.
